// File: rtl/if_stage_if.sv
// rtl/if_stage_if.sv - pre-IF / instruction-RAM / ID signal bundle around the IF stage
interface if_stage_if;
    // pre-IF -> IF entry handshake
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic        in_req_issued;
    logic        in_exception;
    logic [4:0]  in_exccode;
    logic        in_tlb_refill;

    // instruction-RAM read data channel
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    // exception-like cancel
    logic        flush;

    // IF -> ID handshake
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic        out_exception;
    logic [4:0]  out_exccode;
    logic        out_tlb_refill;

    // status back to pre-IF
    logic [31:0] curr_pc;
    logic        stall_wait_for_data;
    logic        discard_pending;

    // environment side: pre-IF, memory bus and ID
    modport master (
        output in_valid, in_pc, in_req_issued, in_exception, in_exccode, in_tlb_refill,
        output inst_sram_data_ok, inst_sram_rdata, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_inst, out_exception, out_exccode,
        input  out_tlb_refill, curr_pc, stall_wait_for_data, discard_pending
    );

    // the IF stage itself
    modport slave (
        input  in_valid, in_pc, in_req_issued, in_exception, in_exccode, in_tlb_refill,
        input  inst_sram_data_ok, inst_sram_rdata, flush, out_ready,
        output in_ready, out_valid, out_pc, out_inst, out_exception, out_exccode,
        output out_tlb_refill, curr_pc, stall_wait_for_data, discard_pending
    );
endinterface

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction-fetch stage with data bypass and stale-beat discard
module if_stage #(
    parameter int DISCARD_W = 2
) (
    input  logic       clk,
    input  logic       reset,
    if_stage_if.slave  bus
);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    // curr_pc + 4 equals the reset vector 0xBFC0_0000 after reset
    localparam logic [31:0]          RESET_PC    = 32'hBFBF_FFFC;
    localparam logic [DISCARD_W-1:0] DISCARD_MAX = '1;
    localparam logic [DISCARD_W-1:0] DISCARD_ONE = DISCARD_W'(1);

    state_t               state;
    logic [31:0]          pc_r;
    logic [31:0]          inst_r;
    logic                 exc_r;
    logic [4:0]           exccode_r;
    logic                 tlb_refill_r;
    logic [DISCARD_W-1:0] discard_cnt;

    logic beat_mine;
    logic out_valid_w;
    logic out_fire;
    logic in_ready_w;
    logic in_fire;
    logic disc_inc;
    logic disc_dec;

    // a beat belongs to the held entry only once every stale beat has drained
    assign beat_mine   = bus.inst_sram_data_ok & (discard_cnt == '0);
    assign out_valid_w = (state == S_HOLD) | ((state == S_WAIT) & beat_mine);
    assign out_fire    = out_valid_w & bus.out_ready & ~bus.flush;
    assign in_ready_w  = (state == S_EMPTY) | out_fire;
    assign in_fire     = bus.in_valid & in_ready_w & ~bus.flush;

    // a flush in WAIT orphans the outstanding request; its beat must be dropped later
    assign disc_inc = bus.flush & (state == S_WAIT) & ~beat_mine;
    assign disc_dec = bus.inst_sram_data_ok & (discard_cnt != '0);

    assign bus.in_ready            = in_ready_w;
    assign bus.out_valid           = out_valid_w;
    assign bus.out_pc              = pc_r;
    assign bus.out_inst            = (state == S_WAIT) ? bus.inst_sram_rdata : inst_r;
    assign bus.out_exception       = exc_r;
    assign bus.out_exccode         = exccode_r;
    assign bus.out_tlb_refill      = tlb_refill_r;
    assign bus.curr_pc             = pc_r;
    assign bus.stall_wait_for_data = (state == S_WAIT) & ~beat_mine;
    assign bus.discard_pending     = (discard_cnt != '0);

    // entry FSM: flush wins, then reload, then hand-off, then latch the arriving word
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_EMPTY;
            pc_r         <= RESET_PC;
            inst_r       <= '0;
            exc_r        <= 1'b0;
            exccode_r    <= '0;
            tlb_refill_r <= 1'b0;
        end else if (bus.flush) begin
            state <= S_EMPTY;
        end else if (in_fire) begin
            pc_r         <= bus.in_pc;
            exc_r        <= bus.in_exception;
            exccode_r    <= bus.in_exccode;
            tlb_refill_r <= bus.in_tlb_refill;
            if (bus.in_req_issued) begin
                state <= S_WAIT;
            end else begin
                // no request went out, so the entry is complete with a null instruction
                state  <= S_HOLD;
                inst_r <= '0;
            end
        end else if (out_fire) begin
            state <= S_EMPTY;
        end else if ((state == S_WAIT) && beat_mine) begin
            inst_r <= bus.inst_sram_rdata;
            state  <= S_HOLD;
        end
    end

    // stale-beat counter: simultaneous new orphan and dropped beat cancel out; saturates
    always_ff @(posedge clk) begin
        if (reset) begin
            discard_cnt <= '0;
        end else if (disc_inc && !disc_dec) begin
            if (discard_cnt != DISCARD_MAX) begin
                discard_cnt <= discard_cnt + DISCARD_ONE;
            end
        end else if (disc_dec && !disc_inc) begin
            discard_cnt <= discard_cnt - DISCARD_ONE;
        end
    end

endmodule
